// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - AHB encodings and fill-state type shared by the cache line-fill master
package cache_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_ADDR,
        FILL_BURST,
        FILL_LAST,
        FILL_ERR
    } fill_state_e;

endpackage

// File: rtl/cache_fill_addr_gen.sv
// rtl/cache_fill_addr_gen.sv - beat address from line base, start word and beat count
// Offset sum is kept to OFF_W bits so a wrapping burst never carries into tag/index bits.
module cache_fill_addr_gen #(
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic [29-OFF_W:0] line_base_i,
    input  logic [OFF_W-1:0]  start_off_i,
    input  logic [OFF_W-1:0]  beat_cnt_i,
    output logic [31:0]       addr_o
);

    logic [OFF_W-1:0] word_off;

    assign word_off = start_off_i + beat_cnt_i;
    assign addr_o   = {line_base_i, word_off, 2'b00};

endmodule

// File: rtl/cache_fill_ahb.sv
// rtl/cache_fill_ahb.sv - 4-beat AHB read-burst line-fill master feeding port 1 of the AHB mux
// Build option: CACHE_FILL_CWF_EN selects critical-word-first (WRAP4) instead of line-base INCR4.
module cache_fill_ahb
    import cache_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] HPROT_VAL  = 4'b1011
) (
    input  logic                          i_hclk,
    input  logic                          i_hnreset,
    input  logic                          i_req,
    input  logic [31:0]                   i_addr,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    output logic                          o_wr_en,
    output logic [$clog2(LINE_WORDS)-1:0] o_wr_idx,
    output logic [31:0]                   o_wr_data,
    output logic                          o_crit,
    output logic                          o_en,
    output logic                          o_hsel,
    output logic [31:0]                   o_haddr,
    output logic                          o_hwrite,
    output logic [2:0]                    o_hsize,
    output logic [2:0]                    o_hburst,
    output logic [3:0]                    o_hprot,
    output logic [1:0]                    o_htrans,
    output logic                          o_hmastlock,
    output logic                          o_hready,
    output logic [31:0]                   o_hwdata,
    input  logic                          i_hready,
    input  logic                          i_hresp,
    input  logic [31:0]                   i_hrdata
);

    localparam int              OFF_W    = $clog2(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

`ifdef CACHE_FILL_CWF_EN
    localparam bit         CWF        = 1'b1;
    localparam logic [2:0] BURST_TYPE = HBURST_WRAP4;
`else
    localparam bit         CWF        = 1'b0;
    localparam logic [2:0] BURST_TYPE = HBURST_INCR4;
`endif

    fill_state_e       state_q;
    logic [29-OFF_W:0] base_q;
    logic [OFF_W-1:0]  start_q;
    logic [OFF_W-1:0]  crit_off_q;
    logic [OFF_W-1:0]  addr_cnt_q;
    logic [OFF_W-1:0]  data_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              en_q;
    logic              hsel_q;
    logic [1:0]        htrans_q;

    logic [31:0]       beat_addr;
    logic [OFF_W-1:0]  req_off;
    logic [OFF_W-1:0]  wr_idx;
    logic              data_phase;
    logic              wr_en;
    logic              bus_err;
    logic              unused_addr_bits;

    assign req_off          = i_addr[OFF_W+1:2];
    assign unused_addr_bits = ^i_addr[1:0];

    cache_fill_addr_gen #(
        .LINE_WORDS (LINE_WORDS)
    ) u_addr_gen (
        .line_base_i (base_q),
        .start_off_i (start_q),
        .beat_cnt_i  (addr_cnt_q),
        .addr_o      (beat_addr)
    );

    // First cycle of a two-cycle ERROR response; the beat is never written.
    assign data_phase = (state_q == FILL_BURST) || (state_q == FILL_LAST);
    assign bus_err    = data_phase && !i_hready && i_hresp;
    assign wr_en      = data_phase && i_hready && !i_hresp;
    assign wr_idx     = start_q + data_cnt_q;

    always_ff @(posedge i_hclk or negedge i_hnreset) begin
        if (!i_hnreset) begin
            state_q    <= FILL_IDLE;
            base_q     <= '0;
            start_q    <= '0;
            crit_off_q <= '0;
            addr_cnt_q <= '0;
            data_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            en_q       <= 1'b0;
            hsel_q     <= 1'b0;
            htrans_q   <= HTRANS_IDLE;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (wr_en) begin
                data_cnt_q <= data_cnt_q + 1'b1;
            end
            case (state_q)
                FILL_IDLE: begin
                    if (i_req && i_hready) begin
                        base_q     <= i_addr[31:OFF_W+2];
                        crit_off_q <= req_off;
                        start_q    <= CWF ? req_off : '0;
                        addr_cnt_q <= '0;
                        data_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        en_q       <= 1'b1;
                        hsel_q     <= 1'b1;
                        htrans_q   <= HTRANS_NONSEQ;
                        state_q    <= FILL_ADDR;
                    end
                end
                FILL_ADDR: begin
                    if (i_hready) begin
                        addr_cnt_q <= addr_cnt_q + 1'b1;
                        htrans_q   <= HTRANS_SEQ;
                        state_q    <= FILL_BURST;
                    end
                end
                FILL_BURST: begin
                    if (bus_err) begin
                        htrans_q <= HTRANS_IDLE;
                        state_q  <= FILL_ERR;
                    end else if (wr_en) begin
                        addr_cnt_q <= addr_cnt_q + 1'b1;
                        if (addr_cnt_q == LAST_CNT) begin
                            // Release the mux now so the CPU port owns the bus after D3.
                            en_q     <= 1'b0;
                            hsel_q   <= 1'b0;
                            htrans_q <= HTRANS_IDLE;
                            state_q  <= FILL_LAST;
                        end
                    end
                end
                FILL_LAST: begin
                    if (bus_err) begin
                        en_q    <= 1'b1;
                        hsel_q  <= 1'b1;
                        state_q <= FILL_ERR;
                    end else if (wr_en) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FILL_IDLE;
                    end
                end
                FILL_ERR: begin
                    if (i_hready) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        en_q    <= 1'b0;
                        hsel_q  <= 1'b0;
                        state_q <= FILL_IDLE;
                    end
                end
                default: state_q <= FILL_IDLE;
            endcase
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_en        = en_q;
    assign o_hsel      = hsel_q;
    assign o_htrans    = htrans_q;
    assign o_haddr     = hsel_q ? beat_addr  : '0;
    assign o_hburst    = hsel_q ? BURST_TYPE : '0;
    assign o_hsize     = hsel_q ? HSIZE_WORD : '0;
    assign o_hprot     = hsel_q ? HPROT_VAL  : '0;
    assign o_hwrite    = 1'b0;
    assign o_hmastlock = 1'b0;
    assign o_hwdata    = '0;
    assign o_hready    = i_hready;

    assign o_wr_en   = wr_en;
    assign o_wr_idx  = wr_idx;
    assign o_wr_data = wr_en ? i_hrdata : '0;
    assign o_crit    = wr_en && (wr_idx == crit_off_q);

endmodule

// File: tb/tb_cache_fill_ahb.sv
// tb/tb_cache_fill_ahb.sv - directed-vector bench for cache_fill_ahb (honours CACHE_FILL_CWF_EN)
module tb_cache_fill_ahb;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_hready = 1'b1;
    logic        i_hresp = 1'b0;
    logic [31:0] i_hrdata = '0;

    logic        o_busy, o_done, o_err, o_wr_en, o_crit, o_en, o_hsel;
    logic        o_hwrite, o_hmastlock, o_hready;
    logic [1:0]  o_wr_idx, o_htrans;
    logic [2:0]  o_hsize, o_hburst;
    logic [3:0]  o_hprot;
    logic [31:0] o_wr_data, o_haddr, o_hwdata;

    always #5 clk = ~clk;

    cache_fill_ahb dut (
        .i_hclk      (clk),
        .i_hnreset   (rst_n),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_wr_en     (o_wr_en),
        .o_wr_idx    (o_wr_idx),
        .o_wr_data   (o_wr_data),
        .o_crit      (o_crit),
        .o_en        (o_en),
        .o_hsel      (o_hsel),
        .o_haddr     (o_haddr),
        .o_hwrite    (o_hwrite),
        .o_hsize     (o_hsize),
        .o_hburst    (o_hburst),
        .o_hprot     (o_hprot),
        .o_htrans    (o_htrans),
        .o_hmastlock (o_hmastlock),
        .o_hready    (o_hready),
        .o_hwdata    (o_hwdata),
        .i_hready    (i_hready),
        .i_hresp     (i_hresp),
        .i_hrdata    (i_hrdata)
    );

`ifdef CACHE_FILL_CWF_EN
    localparam logic [2:0] EXP_BURST = 3'b010;
`else
    localparam logic [2:0] EXP_BURST = 3'b011;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] addr_log [8];
    logic [1:0]  idx_log [8];
    int          n_addr, n_wr, n_nonseq, n_done, done_cyc, crit_cnt;
    logic [1:0]  crit_idx;
    logic        err_seen;
    logic [31:0] exp_addr [4];
    logic [1:0]  exp_idx [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   32'(o_busy),   32'd0);
        check({tag, "_done"},   32'(o_done),   32'd0);
        check({tag, "_err"},    32'(o_err),    32'd0);
        check({tag, "_en"},     32'(o_en),     32'd0);
        check({tag, "_hsel"},   32'(o_hsel),   32'd0);
        check({tag, "_htrans"}, 32'(o_htrans), 32'd0);
        check({tag, "_haddr"},  o_haddr,       32'd0);
        check({tag, "_hburst"}, 32'(o_hburst), 32'd0);
        check({tag, "_wr_en"},  32'(o_wr_en),  32'd0);
        check({tag, "_wr_dat"}, o_wr_data,     32'd0);
        check({tag, "_wr_idx"}, 32'(o_wr_idx), 32'd0);
        check({tag, "_crit"},   32'(o_crit),   32'd0);
    endtask

    // Cycle 0 raises i_req; cycles 1..16 drive the response and log what the DUT does.
    task automatic run_fill(input logic [31:0] addr, input int wait_cyc, input logic [31:0] wait_addr,
                            input int err_cyc, input int req_again, input int last_cyc);
        n_addr = 0; n_wr = 0; n_nonseq = 0; n_done = 0; done_cyc = -1;
        crit_cnt = 0; crit_idx = '0; err_seen = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = addr; i_hready = 1'b1; i_hresp = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            i_req    = (c == req_again);
            i_hready = !(c == wait_cyc || c == err_cyc);
            i_hresp  = (err_cyc > 0) && (c == err_cyc || c == err_cyc + 1);
            i_hrdata = 32'hD000_0000 | 32'(c);
            #1;
            if (c == 1) begin
                check("c1_busy",   32'(o_busy),   32'd1);
                check("c1_htrans", 32'(o_htrans), 32'(HTRANS_NONSEQ));
                check("c1_hburst", 32'(o_hburst), 32'(EXP_BURST));
                check("c1_en",     32'(o_en),     32'd1);
                check("c1_hprot",  32'(o_hprot),  32'hB);
                check("c1_hsize",  32'(o_hsize),  32'd2);
            end
            if (c == wait_cyc) begin
                check("wait_haddr",  o_haddr,       wait_addr);
                check("wait_htrans", 32'(o_htrans), 32'(HTRANS_SEQ));
                check("wait_wr_en",  32'(o_wr_en),  32'd0);
                check("wait_hready", 32'(o_hready), 32'd0);
            end
            if (err_cyc > 0 && c == err_cyc + 1) begin
                check("err_htrans", 32'(o_htrans), 32'(HTRANS_IDLE));
                check("err_en",     32'(o_en),     32'd1);
                check("err_wr_en",  32'(o_wr_en),  32'd0);
            end
            if (c == last_cyc) begin
                check("last_en",   32'(o_en),   32'd0);
                check("last_hsel", 32'(o_hsel), 32'd0);
            end
            if (o_htrans != HTRANS_IDLE && i_hready) begin
                if (n_addr < 8) addr_log[n_addr] = o_haddr;
                n_addr++;
                if (o_htrans == HTRANS_NONSEQ) n_nonseq++;
            end
            if (o_wr_en) begin
                check("wr_data", o_wr_data, 32'hD000_0000 | 32'(c));
                if (n_wr < 8) idx_log[n_wr] = o_wr_idx;
                n_wr++;
                if (o_crit) begin
                    crit_cnt++;
                    crit_idx = o_wr_idx;
                end
            end
            if (o_done) begin
                n_done++;
                done_cyc = c;
                err_seen = o_err;
            end
        end
        i_req = 1'b0; i_hready = 1'b1; i_hresp = 1'b0;
    endtask

    task automatic check_fill(input string tag, input int exp_naddr, input int exp_nwr,
                              input int exp_crit_cnt, input logic [1:0] exp_crit,
                              input int exp_done, input logic exp_err);
        check({tag, "_naddr"}, 32'(n_addr), 32'(exp_naddr));
        for (int i = 0; i < exp_naddr; i++) check({tag, "_haddr"}, addr_log[i], exp_addr[i]);
        check({tag, "_nwr"}, 32'(n_wr), 32'(exp_nwr));
        for (int i = 0; i < exp_nwr; i++) check({tag, "_wr_idx"}, 32'(idx_log[i]), 32'(exp_idx[i]));
        check({tag, "_crit_cnt"}, 32'(crit_cnt), 32'(exp_crit_cnt));
        if (exp_crit_cnt > 0) check({tag, "_crit_idx"}, 32'(crit_idx), 32'(exp_crit));
        check({tag, "_nonseq"}, 32'(n_nonseq), 32'd1);
        check({tag, "_ndone"},  32'(n_done),   32'd1);
        check({tag, "_done_c"}, 32'(done_cyc), 32'(exp_done));
        check({tag, "_err"},    32'(err_seen), 32'(exp_err));
    endtask

    initial begin
        #2;
        check_idle_outputs("rst");
        check("rst_hprot",  32'(o_hprot),  32'd0);
        check("rst_hwrite", 32'(o_hwrite), 32'd0);
        check("rst_hwdata", o_hwdata,      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Zero-wait fill of a mid-line miss.
`ifdef CACHE_FILL_CWF_EN
        exp_addr = '{32'h1000_0008, 32'h1000_000C, 32'h1000_0000, 32'h1000_0004};
        exp_idx  = '{2'd2, 2'd3, 2'd0, 2'd1};
`else
        exp_addr = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C};
        exp_idx  = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
        run_fill(32'h1000_0008, -1, 32'h0, -1, -1, 5);
        check_fill("nowait", 4, 4, 1, 2'd2, 6, 1'b0);

        // Last word of line requested, one wait state on D1; offsets must not carry into 0x40.
`ifdef CACHE_FILL_CWF_EN
        exp_addr = '{32'h2000_003C, 32'h2000_0030, 32'h2000_0034, 32'h2000_0038};
        exp_idx  = '{2'd3, 2'd0, 2'd1, 2'd2};
        run_fill(32'h2000_003D, 3, 32'h2000_0034, -1, -1, 6);
`else
        exp_addr = '{32'h2000_0030, 32'h2000_0034, 32'h2000_0038, 32'h2000_003C};
        exp_idx  = '{2'd0, 2'd1, 2'd2, 2'd3};
        run_fill(32'h2000_003D, 3, 32'h2000_0038, -1, -1, 6);
`endif
        check_fill("wait", 4, 4, 1, 2'd3, 7, 1'b0);

        // ERROR response during D2: A3 never accepted, only D0/D1 written.
`ifdef CACHE_FILL_CWF_EN
        exp_addr = '{32'h1000_0008, 32'h1000_000C, 32'h1000_0000, 32'h0};
        exp_idx  = '{2'd2, 2'd3, 2'd0, 2'd0};
        run_fill(32'h1000_0008, -1, 32'h0, 4, -1, -1);
        check_fill("error", 3, 2, 1, 2'd2, 6, 1'b1);
`else
        exp_addr = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h0};
        exp_idx  = '{2'd0, 2'd1, 2'd0, 2'd0};
        run_fill(32'h1000_0008, -1, 32'h0, 4, -1, -1);
        check_fill("error", 3, 2, 0, 2'd0, 6, 1'b1);
`endif

        // Request pulsed while busy must be ignored.
`ifdef CACHE_FILL_CWF_EN
        exp_addr = '{32'h1000_0008, 32'h1000_000C, 32'h1000_0000, 32'h1000_0004};
        exp_idx  = '{2'd2, 2'd3, 2'd0, 2'd1};
`else
        exp_addr = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C};
        exp_idx  = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
        run_fill(32'h1000_0008, -1, 32'h0, -1, 2, 5);
        check_fill("reqbusy", 4, 4, 1, 2'd2, 6, 1'b0);

        // Asynchronous reset in the middle of BURST.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h3000_0004;
        @(posedge clk); #1;
        i_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_htrans", 32'(o_htrans), 32'(HTRANS_SEQ));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        check("midrst_nodone", 32'(o_done), 32'd0);
        rst_n = 1'b1;

        run_fill(32'h1000_0008, -1, 32'h0, -1, -1, 5);
        check_fill("postrst", 4, 4, 1, 2'd2, 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_ahb.md
# cache_fill_ahb

Cache line-fill master for the PLRU cache. It turns a miss request into one 4-beat AHB read burst and presents it on the cache-side (port 1) input of the AHB bus mux, driving that mux's enable. Returned words are written into the line buffer, with a pulse when the requested (critical) word arrives. It sits directly upstream of the AHB mux, between the miss controller and the shared memory bus.

## Interface
- LINE_WORDS, 4: words per cache line; fixed burst length, power of two.
- HPROT_VAL, 4'b1011: constant hprot for fill beats (cacheable, privileged, data).
- i_hclk  in  1  bus clock; single clock domain.
- i_hnreset  in  1  asynchronous, active-low reset.
- i_req  in  1  fill request, sampled only in IDLE.
- i_addr  in  32  miss byte address; bits [1:0] ignored.
- o_busy  out  1  fill in progress; reset 0.
- o_done  out  1  one-cycle pulse at fill end; reset 0.
- o_err  out  1  valid with o_done: burst ended with ERROR; reset 0.
- o_wr_en  out  1  line-buffer write strobe; reset 0.
- o_wr_idx  out  log2(LINE_WORDS)  word index in line; reset 0.
- o_wr_data  out  32  word data (i_hrdata); reset 0.
- o_crit  out  1  with o_wr_en: this is the requested word; reset 0.
- o_en  out  1  mux select (mux i_en); reset 0.
- o_hsel, o_haddr[31:0], o_hwrite, o_hsize[2:0], o_hburst[2:0], o_hprot[3:0], o_htrans[1:0], o_hmastlock, o_hready, o_hwdata[31:0]  out  AHB address-phase signals to mux port 1; all reset 0.
- i_hready, i_hresp, i_hrdata[31:0]  in  shared downstream bus response.

## Operation
- States: IDLE, ADDR, BURST, LAST, ERR.
- IDLE: i_req=1 and i_hready=1 → latch i_addr, go ADDR; o_busy=1 from next cycle. i_req while busy ignored.
- ADDR: o_en=1, htrans=NONSEQ, haddr=first beat address. i_hready=1 → addr_cnt=1, BURST.
- BURST: htrans=SEQ, haddr=next beat; simultaneously data phase of previous beat. Each i_hready=1 with i_hresp=0: o_wr_en=1, data_cnt++, addr_cnt++. When the last address (addr_cnt=LINE_WORDS-1) is accepted → LAST.
- LAST: o_en=0, htrans=IDLE, hsel=0; wait final data. i_hready=1 → final write, IDLE; o_done pulse next cycle.
- Error: i_hresp=1 with i_hready=0 in any data phase → ERR; ERR drives htrans=IDLE, keeps o_en=1 until i_hready=1, discards that beat (no o_wr_en), then IDLE with o_done=1, o_err=1 next cycle. Remaining beats dropped.
- Constants: hwrite=0, hsize=3'b010, hmastlock=0, hwdata=0, hprot=HPROT_VAL, o_hready=i_hready, hsel=1 in ADDR/BURST/ERR.
- Address: beat address = {line base, word offset}; offset arithmetic modulo LINE_WORDS (wraps within line, never carries into tag/index bits).
- o_wr_idx = offset of the data-phase beat; o_crit=1 for the beat whose offset equals i_addr word offset.
- Async reset mid-burst: immediately IDLE, all outputs 0; no done pulse.

## Timing
- Zero wait states, req at cycle 0: cycle 1 A0 (NONSEQ); cycles 2–4 A1–A3 with D0–D2; cycle 5 D3 (o_en=0); o_done cycle 6.
- Wait states stretch the current cycle; address and htrans held stable while i_hready=0.
- o_wr_en/o_wr_data combinational with the accepting i_hready edge cycle; o_done/o_err registered.
- o_en low in LAST so the mux returns to the CPU port exactly when the final data phase completes.

## Configuration
- CACHE_FILL_CWF_EN defined: critical-word-first; first beat at requested word, hburst=WRAP4 (3'b010); o_crit on first beat.
- Undefined: first beat at line base (offset 0), hburst=INCR4 (3'b011); o_crit on the beat matching requested offset.

## Structure
- cache_pkg: HTRANS_IDLE/NONSEQ/SEQ, HBURST_INCR4/WRAP4, HSIZE_WORD, fill state enum typedef.
- Sub-module cache_fill_addr_gen: line base + start offset + beat count → beat address with modulo wrap.

## Test plan
- CWF on, i_addr=0x1000_0008, zero waits → haddr 0x08,0x0C,0x00,0x04 (+0x1000_0000), hburst=3'b010, o_wr_idx 2,3,0,1, o_crit on idx 2, o_done cycle 6.
- CWF off, same addr → haddr 0x00,0x04,0x08,0x0C, hburst=3'b011, o_crit on idx 2.
- One wait state on beat 1 → haddr/htrans held stable, single o_wr_en per beat, o_done cycle 7.
- ERROR on beat 2 (hresp=1,hready=0 then hresp=1,hready=1) → htrans=IDLE in 2nd cycle, 2 writes only, o_done=o_err=1.
- i_hnreset low during BURST → all outputs 0 immediately, IDLE; new req after reset completes normally.
- i_req pulsed while busy → ignored; exactly one burst, one o_done.
